mmio_master: RTL and testbench
==============================

# mmio_master

Bus initiator between the CPU load/store unit and the 32-bit memory-mapped peripheral bus (timer and siblings). Accepts one request at a time over a valid/ready handshake and decodes it to a one-hot chip select. Runs one or more single-cycle bus beats and returns a one-cycle response. 64-bit accesses are split into 32-bit beats. Wide reads use the hi/lo/hi rollover-safe sequence, so a free-running 64-bit counter such as `mtime` reads coherently.

## Interface
Parameters:
- `NUM_DEV`, 4: number of peripherals, 1..16; one chip select each.
- `RETRY_MAX`, 3: maximum hi-word mismatch retries on a wide read before an error response.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request transfers when `req_valid & req_ready`.
- `req_addr` in 32: byte address. [7:4] is the device index; [3:0] is the register offset.
- `req_write` in 1: 1 = write, 0 = read.
- `req_wide` in 1: 1 = 64-bit access, 0 = 32-bit access.
- `req_wdata` in 64: write data; [31:0] only when narrow.
- `rsp_valid` out 1: one-cycle pulse; no backpressure.
- `rsp_rdata` out 64: read data, zero-extended if narrow; held until the next response.
- `rsp_err` out 1: qualified by `rsp_valid`.
- `bus_cs` out NUM_DEV: one-hot peripheral select.
- `bus_addr` out 4: register offset.
- `bus_op` out 1: 1 = write beat.
- `bus_wdata` out 32: beat write data.
- `bus_rdata` in 32: shared read data; valid combinationally during a read beat.

## Operation
- States: IDLE, NARROW, WR_LO, WR_HI, RD_HI1, RD_LO, RD_HI2, RESP.
- Accept checks (failure goes directly to RESP with `rsp_err=1` and no beat issued):
  - `req_addr[7:4] >= NUM_DEV`.
  - narrow with `req_addr[1:0]!=0`.
  - wide with `req_addr[2:0]!=0`.
  - `req_addr[31:8]!=0`.
- Beat: exactly one cycle with exactly one `bus_cs` bit high and `bus_addr`/`bus_op`/`bus_wdata` stable. All bus outputs are registered and driven to 0 outside beat states.
- Narrow: NARROW beat at `addr[3:0]`. Read samples `bus_rdata` into `rsp_rdata[31:0]` and zeroes [63:32].
- Wide write: WR_LO beat at offset `a` with `wdata[31:0]`, then WR_HI beat at `a+4` with `wdata[63:32]`, then RESP.
- Wide read:
  - RD_HI1 samples `hi1` from `a+4`, RD_LO samples `lo` from `a`, RD_HI2 samples `hi2` from `a+4`.
  - If `hi2==hi1`: result is `{hi1,lo}`, go to RESP.
  - Else: `hi1<=hi2`, retry counter +1, go to RD_LO.
  - If the counter would exceed RETRY_MAX: go to RESP with `rsp_err=1` and `rsp_rdata={hi2,lo}`.
- Writes never retry.
- RESP: `rsp_valid=1` for one cycle, then IDLE. Reads return 0 on error except for the retry-exhaustion case.
- Retry counter is cleared on accept; width is `$clog2(RETRY_MAX+1)`.

## Timing
- Accept occurs in cycle 0, the IDLE cycle with `req_valid` high. Beats start in cycle 1.
- Response latency in cycles after accept:
  - error: 1.
  - narrow: 2.
  - wide write: 3.
  - wide read without retry: 4.
  - wide read: +2 per retry.
- `req_ready` is low from cycle 1 through the RESP cycle and high again the cycle after RESP. The next accept is therefore no earlier than RESP+1; there are no back-to-back accepts.
- Reset values: `req_ready=1` (once out of reset), `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `bus_cs=0`, `bus_addr=0`, `bus_op=0`, `bus_wdata=0`, state IDLE.
- Reset mid-operation abandons the transaction immediately with no response. `bus_cs` and `bus_op` drop asynchronously, so no partial write completes after reset asserts. A wide write interrupted after WR_LO leaves only the low word updated.
- Request fields are captured at accept. Changes to `req_*` after accept are ignored.

## Test plan
- Narrow write then read of device 0 (`addr=0x08`, data `0xDEADBEEF`): cs=0001 at cycle 1 with `bus_op=1`. Readback `rsp_rdata=0x00000000_DEADBEEF` at cycle 2, `rsp_err=0`.
- Wide write to `0x08` with `0x00000001_FFFFFFF0`: beats at offset 8 then 0xC. `rsp_valid` at cycle 3. Wide read of `0x08` returns the same value at cycle 4.
- Wide read of the timer with `mtime` preloaded to `0x0000_0000_FFFF_FFFF` and rtc pulsing every cycle: `hi1=0`, `hi2=1` forces one retry. Result is `{0x00000001,lo}` with `lo` small, `rsp_err=0`, latency 6.
- Model bus whose hi word changes on every read: 4 lo/hi rounds, then `rsp_err=1`.
- Error accepts: `addr=0x50` with NUM_DEV=4, narrow `0x02`, wide `0x04`. Each gives `rsp_valid` and `rsp_err` at cycle 1 and `bus_cs` stays 0.
- Assert `rst_n=0` during WR_HI: `bus_cs` goes to 0 the same cycle, no `rsp_valid`. After release `req_ready=1` and a new narrow read completes normally.

Source files
------------

// File: rtl/mmio_master_if.sv
// Signal bundle between the load/store unit, mmio_master and the 32-bit peripheral bus.
// The master modport is the initiator's view; slave is the view of the CPU and peripherals.
interface mmio_master_if #(
    parameter int unsigned NUM_DEV = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_addr;
    logic               req_write;
    logic               req_wide;
    logic [63:0]        req_wdata;
    logic               rsp_valid;
    logic [63:0]        rsp_rdata;
    logic               rsp_err;
    logic [NUM_DEV-1:0] bus_cs;
    logic [3:0]         bus_addr;
    logic               bus_op;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;

    modport master (
        input  req_valid, req_addr, req_write, req_wide, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_cs, bus_addr, bus_op, bus_wdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wide, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_cs, bus_addr, bus_op, bus_wdata
    );
endinterface

// File: rtl/mmio_master.sv
// Single-outstanding MMIO bus initiator: splits 64-bit accesses into 32-bit beats and reads
// wide registers with a hi/lo/hi sequence so free-running counters come back coherent.
module mmio_master #(
    parameter int unsigned NUM_DEV   = 4,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mmio_master_if.master io_mmio
);
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [2:0] {
        StIdle, StNarrow, StWrLo, StWrHi, StRdHi1, StRdLo, StRdHi2, StResp
    } state_t;

    state_t             r_state, w_state_d;
    logic [7:0]         r_addr, w_addr_d;
    logic               r_write, w_write_d;
    logic [63:0]        r_wdata, w_wdata_d;
    logic [31:0]        r_hi1, w_hi1_d;
    logic [31:0]        r_lo, w_lo_d;
    logic [RW-1:0]      r_retry, w_retry_d;
    logic               r_rsp_valid, w_rsp_valid_d;
    logic               r_rsp_err, w_rsp_err_d;
    logic [63:0]        r_rsp_rdata, w_rsp_rdata_d;
    logic [NUM_DEV-1:0] r_bus_cs, w_bus_cs_d, w_dev_sel;
    logic [3:0]         r_bus_addr, w_bus_addr_d;
    logic               r_bus_op, w_bus_op_d;
    logic [31:0]        r_bus_wdata, w_bus_wdata_d;
    logic               w_bad;

    assign w_bad = (io_mmio.req_addr[31:8] != 24'h0)
                || ({1'b0, io_mmio.req_addr[7:4]} >= 5'(NUM_DEV))
                || (!io_mmio.req_wide && (io_mmio.req_addr[1:0] != 2'b00))
                || (io_mmio.req_wide && (io_mmio.req_addr[2:0] != 3'b000));

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_write_d     = r_write;
        w_wdata_d     = r_wdata;
        w_hi1_d       = r_hi1;
        w_lo_d        = r_lo;
        w_retry_d     = r_retry;
        w_rsp_valid_d = 1'b0;
        w_rsp_err_d   = 1'b0;
        w_rsp_rdata_d = r_rsp_rdata;
        unique case (r_state)
            StIdle: begin
                if (io_mmio.req_valid) begin
                    w_addr_d  = io_mmio.req_addr[7:0];
                    w_write_d = io_mmio.req_write;
                    w_wdata_d = io_mmio.req_wdata;
                    w_retry_d = '0;
                    if (w_bad) begin
                        w_state_d     = StResp;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = '0;
                    end else if (!io_mmio.req_wide) begin
                        w_state_d = StNarrow;
                    end else if (io_mmio.req_write) begin
                        w_state_d = StWrLo;
                    end else begin
                        w_state_d = StRdHi1;
                    end
                end
            end
            StNarrow: begin
                w_state_d     = StResp;
                w_rsp_valid_d = 1'b1;
                w_rsp_rdata_d = r_write ? 64'h0 : {32'h0, io_mmio.bus_rdata};
            end
            StWrLo: w_state_d = StWrHi;
            StWrHi: begin
                w_state_d     = StResp;
                w_rsp_valid_d = 1'b1;
                w_rsp_rdata_d = '0;
            end
            StRdHi1: begin
                w_hi1_d   = io_mmio.bus_rdata;
                w_state_d = StRdLo;
            end
            StRdLo: begin
                w_lo_d    = io_mmio.bus_rdata;
                w_state_d = StRdHi2;
            end
            StRdHi2: begin
                if (io_mmio.bus_rdata == r_hi1) begin
                    w_state_d     = StResp;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_rdata_d = {r_hi1, r_lo};
                end else if (r_retry == RW'(RETRY_MAX)) begin
                    // Give up, but still hand back the most recent halves for diagnosis.
                    w_state_d     = StResp;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_rdata_d = {io_mmio.bus_rdata, r_lo};
                end else begin
                    w_hi1_d   = io_mmio.bus_rdata;
                    w_retry_d = r_retry + RW'(1);
                    w_state_d = StRdLo;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_dev_sel = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            w_dev_sel[i] = (w_addr_d[7:4] == 4'(i));
        end
    end

    // Bus outputs are registered, so they are derived from the state being entered.
    always_comb begin
        w_bus_cs_d    = '0;
        w_bus_addr_d  = '0;
        w_bus_op_d    = 1'b0;
        w_bus_wdata_d = '0;
        unique case (w_state_d)
            StNarrow: begin
                w_bus_cs_d    = w_dev_sel;
                w_bus_addr_d  = w_addr_d[3:0];
                w_bus_op_d    = w_write_d;
                w_bus_wdata_d = w_write_d ? w_wdata_d[31:0] : 32'h0;
            end
            StWrLo: begin
                w_bus_cs_d    = w_dev_sel;
                w_bus_addr_d  = w_addr_d[3:0];
                w_bus_op_d    = 1'b1;
                w_bus_wdata_d = w_wdata_d[31:0];
            end
            StWrHi: begin
                w_bus_cs_d    = w_dev_sel;
                w_bus_addr_d  = w_addr_d[3:0] | 4'h4;
                w_bus_op_d    = 1'b1;
                w_bus_wdata_d = w_wdata_d[63:32];
            end
            StRdHi1, StRdHi2: begin
                w_bus_cs_d   = w_dev_sel;
                w_bus_addr_d = w_addr_d[3:0] | 4'h4;
            end
            StRdLo: begin
                w_bus_cs_d   = w_dev_sel;
                w_bus_addr_d = w_addr_d[3:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_hi1       <= '0;
            r_lo        <= '0;
            r_retry     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_bus_cs    <= '0;
            r_bus_addr  <= '0;
            r_bus_op    <= 1'b0;
            r_bus_wdata <= '0;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_write     <= w_write_d;
            r_wdata     <= w_wdata_d;
            r_hi1       <= w_hi1_d;
            r_lo        <= w_lo_d;
            r_retry     <= w_retry_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_err   <= w_rsp_err_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_bus_cs    <= w_bus_cs_d;
            r_bus_addr  <= w_bus_addr_d;
            r_bus_op    <= w_bus_op_d;
            r_bus_wdata <= w_bus_wdata_d;
        end
    end

    assign io_mmio.req_ready = (r_state == StIdle);
    assign io_mmio.rsp_valid = r_rsp_valid;
    assign io_mmio.rsp_err   = r_rsp_err;
    assign io_mmio.rsp_rdata = r_rsp_rdata;
    assign io_mmio.bus_cs    = r_bus_cs;
    assign io_mmio.bus_addr  = r_bus_addr;
    assign io_mmio.bus_op    = r_bus_op;
    assign io_mmio.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_mmio_master.sv
// Bench for mmio_master: peripheral models (RAM, free-running timer, unstable hi word), a
// transaction-level reference predicting every cycle's outputs, and directed literal checks.
module tb_mmio_master;
    localparam int unsigned NUM_DEV   = 4;
    localparam int unsigned RETRY_MAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_master_if #(.NUM_DEV(NUM_DEV)) mif ();

    mmio_master #(.NUM_DEV(NUM_DEV), .RETRY_MAX(RETRY_MAX)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mmio (mif)
    );

    typedef struct {
        int          cyc;
        bit          beat;
        int          dev;
        logic [3:0]  baddr;
        bit          op;
        logic [31:0] wd;
        bit          rsp;
        bit          err;
        bit          chk_rd;
        logic [63:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [NUM_DEV-1:0] ce_cs;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    int          exp_acc = -1;
    int          exp_resp = -1;
    logic [63:0] t_base = 64'h0;
    int          n_base = 0;
    logic [31:0] bus_mem   [16][4];
    logic [31:0] model_mem [16][4];
    int          rb_dev;
    logic [63:0] rb_t;
    int          wr_dev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cs_index(logic [NUM_DEV-1:0] cs);
        for (int i = 0; i < NUM_DEV; i++) if (cs[i]) return i;
        return -1;
    endfunction

    // Peripherals: dev1 = free-running mtime (read-only), dev2 hi word = cycle count, else RAM.
    always_comb begin
        rb_dev = cs_index(mif.bus_cs);
        rb_t   = t_base + 64'(cyc - n_base);
        mif.bus_rdata = 32'hA5A5_5A5A;
        if (rb_dev == 1) mif.bus_rdata = mif.bus_addr[2] ? rb_t[63:32] : rb_t[31:0];
        else if (rb_dev == 2 && mif.bus_addr[2]) mif.bus_rdata = 32'(cyc);
        else if (rb_dev >= 0) mif.bus_rdata = bus_mem[rb_dev][mif.bus_addr[3:2]];
    end

    always @(posedge clk) begin
        wr_dev = cs_index(mif.bus_cs);
        if (mif.bus_op && wr_dev >= 0 && wr_dev != 1)
            bus_mem[wr_dev][mif.bus_addr[3:2]] <= mif.bus_wdata;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic logic [31:0] model_rd(int d, logic [3:0] o, int n);
        logic [63:0] t;
        t = t_base + 64'(n - n_base);
        if (d == 1) return o[2] ? t[63:32] : t[31:0];
        if (d == 2 && o[2]) return 32'(n);
        return model_mem[d][o[3:2]];
    endfunction

    function automatic void model_wr(int d, logic [3:0] o, logic [31:0] v);
        if (d != 1) model_mem[d][o[3:2]] = v;
    endfunction

    function automatic void push_beat(int n, int d, logic [3:0] o, bit op, logic [31:0] wd);
        exp_t e;
        e = '{default: '0};
        e.cyc = n; e.beat = 1'b1; e.dev = d; e.baddr = o; e.op = op; e.wd = wd;
        exp_q.push_back(e);
    endfunction

    function automatic void push_rsp(int n, bit err, bit chk_rd, logic [63:0] rd);
        exp_t e;
        e = '{default: '0};
        e.cyc = n; e.rsp = 1'b1; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
        exp_q.push_back(e);
    endfunction

    // Transaction-level reference: lays out the expected beats and response after accept cycle acc.
    function automatic void model_txn(int acc, logic [31:0] a, logic w, logic wide,
                                      logic [63:0] dat);
        int n, d, retries;
        logic [3:0] o;
        logic [31:0] hi1, lo, hi2, v;
        bit bad;
        n = acc + 1;
        d = int'(a[7:4]);
        o = a[3:0];
        bad = (a[31:8] != 24'h0) || (d >= NUM_DEV) || (!wide && a[1:0] != 2'b00)
           || (wide && a[2:0] != 3'b000);
        exp_acc = acc;
        if (bad) begin
            push_rsp(n, 1'b1, !w, 64'h0);
            exp_resp = n;
        end else if (!wide) begin
            push_beat(n, d, o, w, w ? dat[31:0] : 32'h0);
            if (w) begin
                model_wr(d, o, dat[31:0]);
                v = 32'h0;
            end else begin
                v = model_rd(d, o, n);
            end
            push_rsp(n + 1, 1'b0, !w, {32'h0, v});
            exp_resp = n + 1;
        end else if (w) begin
            push_beat(n, d, o, 1'b1, dat[31:0]);
            push_beat(n + 1, d, o + 4'd4, 1'b1, dat[63:32]);
            model_wr(d, o, dat[31:0]);
            model_wr(d, o + 4'd4, dat[63:32]);
            push_rsp(n + 2, 1'b0, 1'b0, 64'h0);
            exp_resp = n + 2;
        end else begin
            hi1 = model_rd(d, o + 4'd4, n);
            push_beat(n, d, o + 4'd4, 1'b0, 32'h0);
            n++;
            retries = 0;
            while (1) begin
                lo = model_rd(d, o, n);
                push_beat(n, d, o, 1'b0, 32'h0);
                n++;
                hi2 = model_rd(d, o + 4'd4, n);
                push_beat(n, d, o + 4'd4, 1'b0, 32'h0);
                n++;
                if (hi2 == hi1) begin
                    push_rsp(n, 1'b0, 1'b1, {hi1, lo});
                    break;
                end
                if (retries == RETRY_MAX) begin
                    push_rsp(n, 1'b1, 1'b1, {hi2, lo});
                    break;
                end
                retries++;
                hi1 = hi2;
            end
            exp_resp = n;
        end
    endfunction

    // Per-cycle comparison of every output against the reference schedule.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            ce = '{default: '0};
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) ce = exp_q.pop_front();
            ce_cs = '0;
            if (ce.beat) ce_cs[ce.dev] = 1'b1;
            chk("bus_cs", mif.bus_cs, ce_cs);
            chk("bus_addr", mif.bus_addr, ce.beat ? ce.baddr : 4'h0);
            chk("bus_op", mif.bus_op, ce.beat ? ce.op : 1'b0);
            if (!ce.beat || ce.op) chk("bus_wdata", mif.bus_wdata, ce.beat ? ce.wd : 32'h0);
            chk("rsp_valid", mif.rsp_valid, ce.rsp);
            if (ce.rsp) chk("rsp_err", mif.rsp_err, ce.err);
            if (ce.rsp && ce.chk_rd) chk("rsp_rdata", mif.rsp_rdata, ce.rd);
            chk("req_ready", mif.req_ready, !(cyc > exp_acc && cyc <= exp_resp));
        end
    end

    task automatic wait_idle();
        while (cyc <= exp_resp) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic [31:0] a, input logic w, input logic wide,
                         input logic [63:0] dat, output int acc);
        wait_idle();
        mif.req_valid = 1'b1;
        mif.req_addr  = a;
        mif.req_write = w;
        mif.req_wide  = wide;
        mif.req_wdata = dat;
        acc = cyc;
        model_txn(acc, a, w, wide, dat);
        @(negedge clk);
        mif.req_valid = 1'b0;
        mif.req_addr  = $urandom;
        mif.req_write = 1'($urandom);
        mif.req_wide  = 1'($urandom);
        mif.req_wdata = {$urandom, $urandom};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [31:0] a;
        logic [3:0] d, o;
        logic w, wide;
        logic [31:0] v;
        mif.req_valid = 1'b0;
        mif.req_addr  = '0;
        mif.req_write = 1'b0;
        mif.req_wide  = 1'b0;
        mif.req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                v = $urandom;
                bus_mem[i][k] <= v;
                model_mem[i][k] = v;
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset req_ready", mif.req_ready, 1'b1);
        chk("reset rsp_valid", mif.rsp_valid, 1'b0);
        chk("reset rsp_err", mif.rsp_err, 1'b0);
        chk("reset rsp_rdata", mif.rsp_rdata, 64'h0);
        chk("reset bus_cs", mif.bus_cs, 4'b0000);
        chk("reset bus_addr/op/wdata", {mif.bus_addr, mif.bus_op, mif.bus_wdata}, 37'h0);
        chk_en = 1'b1;

        // Narrow write then read of device 0.
        issue(32'h08, 1'b1, 1'b0, 64'hDEAD_BEEF, acc);
        chk("t1 cs", mif.bus_cs, 4'b0001);
        chk("t1 op", mif.bus_op, 1'b1);
        chk("t1 wdata", mif.bus_wdata, 32'hDEAD_BEEF);
        issue(32'h08, 1'b0, 1'b0, 64'h0, acc);
        wait_cyc(acc + 2);
        chk("t1 rd valid", mif.rsp_valid, 1'b1);
        chk("t1 rd data", mif.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("t1 rd err", mif.rsp_err, 1'b0);

        // Wide write / read round trip.
        issue(32'h08, 1'b1, 1'b1, 64'h0000_0001_FFFF_FFF0, acc);
        chk("t2 lo addr", mif.bus_addr, 4'h8);
        wait_cyc(acc + 2);
        chk("t2 hi addr", mif.bus_addr, 4'hC);
        chk("t2 hi wdata", mif.bus_wdata, 32'h0000_0001);
        wait_cyc(acc + 3);
        chk("t2 wr valid", mif.rsp_valid, 1'b1);
        issue(32'h08, 1'b0, 1'b1, 64'h0, acc);
        wait_cyc(acc + 4);
        chk("t2 rd valid", mif.rsp_valid, 1'b1);
        chk("t2 rd data", mif.rsp_rdata, 64'h0000_0001_FFFF_FFF0);

        // mtime rolls over between hi1 and hi2: exactly one retry.
        wait_idle();
        t_base = 64'h0000_0000_FFFF_FFFF;
        n_base = cyc + 1;
        issue(32'h10, 1'b0, 1'b1, 64'h0, acc);
        wait_cyc(acc + 4);
        chk("t3 no early rsp", mif.rsp_valid, 1'b0);
        wait_cyc(acc + 6);
        chk("t3 valid", mif.rsp_valid, 1'b1);
        chk("t3 data", mif.rsp_rdata, 64'h0000_0001_0000_0002);
        chk("t3 err", mif.rsp_err, 1'b0);

        // Hi word never stable: retries exhaust.
        issue(32'h20, 1'b1, 1'b0, 64'h1234_5678, acc);
        issue(32'h20, 1'b0, 1'b1, 64'h0, acc);
        wait_cyc(acc + 10);
        chk("t4 valid", mif.rsp_valid, 1'b1);
        chk("t4 err", mif.rsp_err, 1'b1);
        chk("t4 data", mif.rsp_rdata, {32'(acc + 9), 32'h1234_5678});

        // Rejected accepts.
        issue(32'h50, 1'b0, 1'b0, 64'h0, acc);
        chk("t5 dev valid", {mif.rsp_valid, mif.rsp_err}, 2'b11);
        chk("t5 dev cs", mif.bus_cs, 4'b0000);
        issue(32'h02, 1'b0, 1'b0, 64'h0, acc);
        chk("t5 narrow align", {mif.rsp_valid, mif.rsp_err}, 2'b11);
        chk("t5 narrow cs", mif.bus_cs, 4'b0000);
        issue(32'h04, 1'b0, 1'b1, 64'h0, acc);
        chk("t5 wide align", {mif.rsp_valid, mif.rsp_err}, 2'b11);
        chk("t5 wide cs", mif.bus_cs, 4'b0000);

        // Reset during WR_HI: only the low word lands.
        issue(32'h3C, 1'b1, 1'b0, 64'h0BAD_0BAD, acc);
        issue(32'h38, 1'b1, 1'b1, 64'h1111_2222_3333_4444, acc);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        exp_q.delete();
        exp_acc  = -1;
        exp_resp = -1;
        #1;
        chk("t6 cs async drop", mif.bus_cs, 4'b0000);
        chk("t6 op async drop", mif.bus_op, 1'b0);
        chk("t6 no rsp", mif.rsp_valid, 1'b0);
        model_mem[3][3] = 32'h0BAD_0BAD;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("t6 ready after reset", mif.req_ready, 1'b1);
        chk_en = 1'b1;
        issue(32'h3C, 1'b0, 1'b0, 64'h0, acc);
        wait_cyc(acc + 2);
        chk("t6 hi untouched", mif.rsp_rdata, 64'h0000_0000_0BAD_0BAD);
        issue(32'h38, 1'b0, 1'b0, 64'h0, acc);
        wait_cyc(acc + 2);
        chk("t6 lo written", mif.rsp_rdata, 64'h0000_0000_3333_4444);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            d    = 4'($urandom_range(0, NUM_DEV));
            wide = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            o    = wide ? 4'($urandom_range(0, 1) * 8) : 4'($urandom_range(0, 3) * 4);
            a    = {24'h0, d, o};
            case ($urandom_range(0, 19))
                0: a[1:0] = 2'($urandom_range(1, 3));
                1: a[31:8] = 24'($urandom_range(1, 24'hFF_FFFF));
                2: a[2] = 1'b1;
                default: begin
                end
            endcase
            if (d == 4'd1 && $urandom_range(0, 1) == 1) begin
                wait_idle();
                t_base = {$urandom, 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))};
                n_base = cyc;
            end
            issue(a, w, wide, {$urandom, $urandom}, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
